// File: rtl/mem_bus_responder.sv
// Line-granular memory responder on the cache request/response bus.
// Define MEM_BUS_ERR_CNT_EN to add the saturating err_count output.
`ifndef MEM_READ
`define MEM_READ 13'h1
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 13'h2
`endif

module mem_bus_responder #(
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 13,
  parameter int DEPTH   = 1024,
  parameter int BEATS   = 8,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_reqcyc,
  output logic              bus_reqack,
  input  logic [DATA_W-1:0] bus_req,
  input  logic [TAG_W-1:0]  bus_reqtag,
  output logic              bus_respcyc,
  input  logic              bus_respack,
  output logic [DATA_W-1:0] bus_resp,
  output logic [TAG_W-1:0]  bus_resptag
`ifdef MEM_BUS_ERR_CNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;
  localparam logic [TAG_W-1:0] TAG_RD = TAG_W'(`MEM_READ);
  localparam logic [TAG_W-1:0] TAG_WR = TAG_W'(`MEM_WRITE);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, ACK, LAT, RBEAT, WDATA, WDONE
  } state_t;

  state_t state, nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [TAG_W-1:0]  tag_q;
  logic [AW-1:0]     line_q;
  logic              oor_q;
  logic [CW-1:0]     cnt;
  logic              ack_q;
  logic [DATA_W-1:0] rdata;
  logic              wr_acc;
  logic              accept;
  logic              load_rd;
  logic [AW-1:0]     rd_idx;

  assign wr_acc  = (state == WDATA) && bus_reqcyc && !ack_q;
  assign accept  = ((state == IDLE) && bus_reqcyc) || wr_acc;
  assign load_rd = (nxt == RBEAT) && ((state != RBEAT) || bus_respack);
  assign rd_idx  = (state == RBEAT) ? line_q + AW'(cnt) + AW'(1) : line_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (bus_reqcyc) nxt = ACK;
      ACK: begin
        if (tag_q == TAG_RD)      nxt = (LATENCY == 1) ? RBEAT : LAT;
        else if (tag_q == TAG_WR) nxt = WDATA;
        else                      nxt = IDLE;
      end
      LAT:   if (cnt == CW'(1)) nxt = RBEAT;
      RBEAT: if (bus_respack && cnt == LAST) nxt = IDLE;
      WDATA: if (wr_acc && cnt == LAST) nxt = WDONE;
      WDONE: if (bus_respack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_reqack  = ack_q;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    unique case (state)
      RBEAT: begin
        bus_respcyc = 1'b1;
        bus_resp    = rdata;
        bus_resptag = TAG_RD;
      end
      WDONE: begin
        bus_respcyc = 1'b1;
        bus_resptag = TAG_WR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q  <= '0;
      line_q <= '0;
      oor_q  <= 1'b0;
      cnt    <= '0;
      ack_q  <= 1'b0;
      rdata  <= '0;
    end else begin
      ack_q <= accept;
      unique case (state)
        IDLE: if (bus_reqcyc) begin
          tag_q  <= bus_reqtag;
          line_q <= bus_req[AW+2:3] & ~AW'(BEATS - 1);
          oor_q  <= |bus_req[DATA_W-1:AW+3];
          cnt    <= '0;
        end
        ACK:   cnt <= (tag_q == TAG_RD) ? CW'(LATENCY - 1) : '0;
        LAT:   cnt <= cnt - CW'(1);
        RBEAT: if (bus_respack && cnt != LAST) cnt <= cnt + CW'(1);
        WDATA: if (wr_acc) cnt <= cnt + CW'(1);
        default: ;
      endcase
      if (load_rd) rdata <= oor_q ? '0 : mem[rd_idx];
    end
  end

  // Array is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !oor_q) mem[line_q + AW'(cnt)] <= bus_req;
  end

`ifdef MEM_BUS_ERR_CNT_EN
  logic bad_req;
  assign bad_req = (state == ACK) &&
                   (oor_q || (tag_q != TAG_RD && tag_q != TAG_WR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_count <= '0;
    else if (bad_req && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: line model plus expected-beat queue,
// checked every cycle by one monitor process.
`ifndef MEM_READ
`define MEM_READ 13'h1
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 13'h2
`endif

module tb_mem_bus_responder;
  localparam int DATA_W  = 64;
  localparam int TAG_W   = 13;
  localparam int DEPTH   = 1024;
  localparam int BEATS   = 8;
  localparam int LATENCY = 4;
  localparam logic [TAG_W-1:0] RD = TAG_W'(`MEM_READ);
  localparam logic [TAG_W-1:0] WR = TAG_W'(`MEM_WRITE);

  logic              clk = 1'b0;
  logic              reset;
  logic              bus_reqcyc;
  logic              bus_reqack;
  logic [DATA_W-1:0] bus_req;
  logic [TAG_W-1:0]  bus_reqtag;
  logic              bus_respcyc;
  logic              bus_respack;
  logic [DATA_W-1:0] bus_resp;
  logic [TAG_W-1:0]  bus_resptag;
`ifdef MEM_BUS_ERR_CNT_EN
  logic [15:0]       err_count;
`endif

  mem_bus_responder #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH),
    .BEATS(BEATS), .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_reqcyc(bus_reqcyc),
    .bus_reqack(bus_reqack),
    .bus_req(bus_req),
    .bus_reqtag(bus_reqtag),
    .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack),
    .bus_resp(bus_resp),
    .bus_resptag(bus_resptag)
`ifdef MEM_BUS_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
  } beat_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] ref_mem [int];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acks = 0;
  int popped = 0;
  bit prev_ack = 0;

  function automatic logic [DATA_W-1:0] line_base(input logic [DATA_W-1:0] a);
    return a & ~DATA_W'(BEATS * 8 - 1);
  endfunction

  function automatic bit out_of_range(input logic [DATA_W-1:0] a);
    return (a >> (3 + $clog2(DEPTH))) != 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", nm, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every cycle, check outputs against the head of the expected queue.
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset) prev_ack = 0;
    else begin
      if (bus_reqack) begin
        acks++;
        total++;
        if (prev_ack) begin
          bad++;
          $display("FAIL ack_pulse got=2-cycle reqack required=1-cycle");
        end
      end
      prev_ack = bus_reqack;
      if (bus_respcyc) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat got=%0h/%0h required=no beat", bus_resp, bus_resptag);
        end else begin
          if (bus_resp !== exp_q[0].d || bus_resptag !== exp_q[0].t) begin
            bad++;
            $display("FAIL beat got=%0h/%0h required=%0h/%0h",
                     bus_resp, bus_resptag, exp_q[0].d, exp_q[0].t);
          end
          if (bus_respack) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end else begin
        total++;
        if (bus_resp !== '0) begin
          bad++;
          $display("FAIL idle_resp got=%0h required=0", bus_resp);
        end
      end
    end
  end

  task automatic push_read(input logic [DATA_W-1:0] a);
    logic [DATA_W-1:0] b;
    beat_t e;
    b = line_base(a);
    for (int i = 0; i < BEATS; i++) begin
      e.t = RD;
      if (out_of_range(a)) e.d = '0;
      else e.d = ref_mem[int'(b >> 3) + i];
      exp_q.push_back(e);
    end
  endtask

  task automatic req(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                     input string nm);
    bit got;
    got = 0;
    bus_req = d;
    bus_reqtag = t;
    bus_reqcyc = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus_reqack) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_ack_timeout got=no reqack required=reqack", nm);
    end
  endtask

  task automatic drain(input int mode, input string nm);
    int k;
    k = 1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (mode == 1) bus_respack = (k % 3 == 0);
      k++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain got=%0d beats left required=0", nm, exp_q.size());
      exp_q.delete();
    end
    bus_respack = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wr_line(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d0,
                         input string nm);
    beat_t e;
    logic [DATA_W-1:0] b;
    b = line_base(a);
    if (!out_of_range(a))
      for (int i = 0; i < BEATS; i++) ref_mem[int'(b >> 3) + i] = d0 + DATA_W'(i);
    e.d = '0;
    e.t = WR;
    exp_q.push_back(e);
    req(a, WR, nm);
    for (int i = 0; i < BEATS; i++) req(d0 + DATA_W'(i), WR, nm);
    bus_reqcyc = 1'b0;
    drain(0, nm);
  endtask

  task automatic rd_line(input logic [DATA_W-1:0] a, input int mode,
                         input logic [DATA_W-1:0] first, input string nm);
    int t0;
    bit seen;
    seen = 0;
    push_read(a);
    req(a, RD, nm);
    bus_reqcyc = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus_respcyc) seen = 1;
    end
    chk({nm, "_lat"}, 64'(cyc - t0), 64'(LATENCY));
    chk({nm, "_first"}, bus_resp, first);
    drain(mode, nm);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=hang required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, p0, n, t_last, t_ack2, rc;
    reset = 1'b0;
    bus_reqcyc = 1'b0;
    bus_req = '0;
    bus_reqtag = '0;
    bus_respack = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_reqack", 64'(bus_reqack), 0);
    chk("rst_respcyc", 64'(bus_respcyc), 0);
    chk("rst_resp", bus_resp, 0);
    chk("rst_resptag", 64'(bus_resptag), 0);
`ifdef MEM_BUS_ERR_CNT_EN
    chk("rst_errcnt", 64'(err_count), 0);
`endif
    reset = 1'b1;
    @(negedge clk);

    a0 = acks;
    wr_line(64'h40, 64'h1000, "t1");
    chk("t1_acks", 64'(acks - a0), 9);

    rd_line(64'h48, 0, 64'h1000, "t2");
    rd_line(64'h48, 1, 64'h1000, "t3");

    rd_line(64'h10000, 0, 64'h0, "t4");
`ifdef MEM_BUS_ERR_CNT_EN
    chk("t4_errcnt", 64'(err_count), 1);
`endif

    wr_line(64'h1FC8, 64'hA0, "tb_top");
    rd_line(64'h1FF8, 0, 64'hA0, "tb_top_rd");

    // Request held high across two back-to-back reads.
    p0 = popped;
    push_read(64'h40);
    push_read(64'h40);
    bus_req = 64'h40;
    bus_reqtag = RD;
    bus_reqcyc = 1'b1;
    n = 0;
    t_last = 0;
    t_ack2 = 0;
    for (int i = 0; i < 200 && t_ack2 == 0; i++) begin
      @(negedge clk);
      if (t_last == 0 && popped >= p0 + BEATS) t_last = cyc;
      if (bus_reqack) begin
        n++;
        if (n == 2) begin
          t_ack2 = cyc;
          bus_reqcyc = 1'b0;
        end
      end
    end
    bus_reqcyc = 1'b0;
    chk("t5_acks", 64'(n), 2);
    chk("t5_ack_after_last", 64'(t_last != 0 && t_ack2 > t_last), 1);
    drain(0, "t5");

    // Reset during beat 3 of a read.
    p0 = popped;
    push_read(64'h40);
    req(64'h40, RD, "t6");
    bus_reqcyc = 1'b0;
    for (int i = 0; i < 100 && popped < p0 + 3; i++) @(negedge clk);
    reset = 1'b0;
    #2;
    chk("t6_reqack", 64'(bus_reqack), 0);
    chk("t6_respcyc", 64'(bus_respcyc), 0);
    chk("t6_resp", bus_resp, 0);
    chk("t6_resptag", 64'(bus_resptag), 0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("t6_hold", 64'(bus_respcyc), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    rd_line(64'h40, 0, 64'h1000, "t6b");

    // Unknown tag: acked, no response.
    req(64'h80, 13'h7, "t7");
    bus_reqcyc = 1'b0;
    rc = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_respcyc) rc++;
    end
    chk("t7_no_resp", 64'(rc), 0);
`ifdef MEM_BUS_ERR_CNT_EN
    chk("t7_errcnt", 64'(err_count), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
